// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal controller: GO/WARN/CLEAR per phase, with a latched
// pedestrian request that inserts an all-stop WALK interval at the next CLEAR exit.
module traffic_phase_ctrl #(
  parameter int unsigned NPHASE = 2,
  parameter int unsigned NBITS  = 32,
  parameter int unsigned T_GO   = 32'h3938700,
  parameter int unsigned T_WARN = 32'h1C9C380,
  parameter int unsigned T_CLR  = 32'h0989680,
  parameter int unsigned T_WALK = 32'h5F5E100,
  parameter int unsigned PW     = $clog2(NPHASE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              b,
  output logic [NPHASE-1:0] go,
  output logic [NPHASE-1:0] warn,
  output logic [NPHASE-1:0] stop,
  output logic              walk,
  output logic              ped_pend,
  output logic [PW-1:0]     cur_phase
);

  typedef enum logic [1:0] {StClear, StGo, StWarn, StWalk} state_e;

  localparam logic [NBITS-1:0] LdGo   = NBITS'(T_GO - 1);
  localparam logic [NBITS-1:0] LdWarn = NBITS'(T_WARN - 1);
  localparam logic [NBITS-1:0] LdClr  = NBITS'(T_CLR - 1);
  localparam logic [NBITS-1:0] LdWalk = NBITS'(T_WALK - 1);

  state_e            state_q, state_d;
  logic [NBITS-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     phase_q, phase_d, phase_adv;
  logic              first_q, first_d;
  logic              ped_q, ped_d;
  logic [NPHASE-1:0] sel;
  logic [NPHASE-1:0] go_q, go_d, warn_q, warn_d, stop_q, stop_d;
  logic              walk_q, walk_d;

  // The very first GO after reset keeps phase 0 instead of advancing.
  always_comb begin
    if (first_q) begin
      phase_adv = '0;
    end else if (phase_q == PW'(NPHASE - 1)) begin
      phase_adv = '0;
    end else begin
      phase_adv = phase_q + PW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - NBITS'(1);
    phase_d = phase_q;
    first_d = first_q;
    if (cnt_q == '0) begin
      unique case (state_q)
        StClear: begin
          if (ped_q || b) begin
            state_d = StWalk;
            cnt_d   = LdWalk;
          end else begin
            state_d = StGo;
            cnt_d   = LdGo;
            phase_d = phase_adv;
            first_d = 1'b0;
          end
        end
        StGo: begin
          state_d = StWarn;
          cnt_d   = LdWarn;
        end
        StWarn: begin
          state_d = StClear;
          cnt_d   = LdClr;
        end
        StWalk: begin
          state_d = StGo;
          cnt_d   = LdGo;
          phase_d = phase_adv;
          first_d = 1'b0;
        end
      endcase
    end
  end

  // Entering WALK serves the request; presses while in WALK are dropped.
  always_comb begin
    ped_d = ped_q;
    if (state_d == StWalk && state_q != StWalk) begin
      ped_d = 1'b0;
    end else if (state_q != StWalk && b) begin
      ped_d = 1'b1;
    end
  end

  // Lamps are decoded from the next state so they switch on the same edge as the FSM.
  always_comb begin
    sel    = NPHASE'(1) << phase_d;
    go_d   = (state_d == StGo) ? sel : '0;
    warn_d = (state_d == StWarn) ? sel : '0;
    stop_d = (state_d == StGo || state_d == StWarn) ? ~sel : '1;
    walk_d = (state_d == StWalk);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClear;
      cnt_q   <= LdClr;
      phase_q <= '0;
      first_q <= 1'b1;
      ped_q   <= 1'b0;
      go_q    <= '0;
      warn_q  <= '0;
      stop_q  <= '1;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      first_q <= first_d;
      ped_q   <= ped_d;
      go_q    <= go_d;
      warn_q  <= warn_d;
      stop_q  <= stop_d;
      walk_q  <= walk_d;
    end
  end

  assign go        = go_q;
  assign warn      = warn_q;
  assign stop      = stop_q;
  assign walk      = walk_q;
  assign ped_pend  = ped_q;
  assign cur_phase = phase_q;

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised multi-phase traffic signal controller with pedestrian-crossing insertion, succeeding the fixed two-road A/B controller. Sequences NPHASE conflicting phases through GO, WARN (amber) and all-stop CLEAR intervals, using an internal down-counter of NBITS width. A latched pedestrian request inserts an all-stop WALK interval between phases. It sits at the top of the signal datapath and drives lamp and walk outputs directly.

## Interface
- NPHASE, 2: number of phases; legal range ≥ 2.
- NBITS, 32: interval counter width.
- T_GO, 32'h3938700: green cycles per phase; legal range ≥ 1.
- T_WARN, 32'h1C9C380: amber cycles; legal range ≥ 1.
- T_CLR, 32'h0989680: all-stop clearance cycles; legal range ≥ 1.
- T_WALK, 32'h5F5E100: pedestrian walk cycles; legal range ≥ 1.
- PW, $clog2(NPHASE): phase index width (derived).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- b  in  1  pedestrian request button; level, sampled on posedge.
- go  out  NPHASE  one-hot green; bit i = phase i.
- warn  out  NPHASE  one-hot amber.
- stop  out  NPHASE  red per phase.
- walk  out  1  pedestrian walk lamp.
- ped_pend  out  1  request latched, not yet served.
- cur_phase  out  PW  index of active or most recent phase.

## Operation
- States: CLEAR, GO, WARN, WALK. Encoding is free.
- Counter `cnt`:
  - On entry to each state, load (interval − 1).
  - Decrement each cycle.
  - Leave the state on the cycle `cnt == 0`.
  - Each state therefore lasts exactly its T_* cycles.
- Transitions:
  - CLEAR → WALK if (ped_pend | b), else → GO with cur_phase advanced.
  - GO → WARN.
  - WARN → CLEAR.
  - WALK → GO with cur_phase advanced.
- Phase advance: cur_phase + 1, wrapping from NPHASE−1 to 0.
  - The first GO after reset is an exception: it uses phase 0 with no advance. A `first` flag, set by reset and cleared on the first GO entry, implements this.
- Lamp outputs per state:
  - GO: go[cur_phase] = 1, all other go bits 0; stop = all ones except bit cur_phase; warn = 0.
  - WARN: warn[cur_phase] = 1; stop = all ones except bit cur_phase; go = 0.
  - CLEAR and WALK: stop = all ones; go = 0; warn = 0.
  - walk = 1 only in WALK.
- Invariants, checkable every cycle:
  - At most one bit set across go|warn.
  - walk = 1 implies go = 0 and warn = 0.
  - For every i, exactly one of go[i], warn[i], stop[i] is set.
- Pedestrian latch:
  - ped_pend sets on any posedge with b = 1 while not in WALK.
  - ped_pend clears on the WALK entry edge.
  - b during WALK is ignored: no re-latch.
  - Repeated presses are idempotent.

## Timing
- All outputs are registered. They change on the same posedge as the state change, with no combinational paths from b.
- Reset (reset_n low, asynchronous):
  - state = CLEAR, cnt = T_CLR − 1, cur_phase = 0, first = 1.
  - go = 0, warn = 0, stop = all ones, walk = 0, ped_pend = 0.
- After reset_n deasserts: T_CLR cycles of CLEAR, then GO phase 0.
- Reset mid-interval aborts immediately to the reset state. ped_pend is lost.
- Request latency: a request is served at the next CLEAR exit.
  - Worst case: T_GO + T_WARN + T_CLR cycles after the press.
- b high on the CLEAR-exit edge itself: WALK is taken (OR with ped_pend); ped_pend stays 0.
- Full cycle without requests: NPHASE × (T_GO + T_WARN + T_CLR) cycles.
- A served request adds T_WALK cycles and does not skip any phase.
- cnt is NBITS wide. T_* values must fit in NBITS; no saturation logic.

## Test plan
All scenarios use NPHASE=3, T_GO=4, T_WARN=2, T_CLR=1, T_WALK=3.
- Reset/startup:
  - Stimulus: hold reset_n low 3 cycles, then release.
  - Required response: stop=3'b111 during reset and for 1 cycle after; then go=3'b001 for 4 cycles, warn=3'b001 for 2, stop=3'b111 for 1, go=3'b010.
- Wrap-around:
  - Stimulus: run 21 cycles from first GO with no requests.
  - Required response: phases 0,1,2 in order; cur_phase returns to 0; go=3'b001 again at cycle 21.
- Pedestrian insertion:
  - Stimulus: pulse b one cycle during GO phase 0.
  - Required response: ped_pend=1 next cycle; after CLEAR, walk=1 and stop=3'b111 for 3 cycles; ped_pend=0 at WALK entry; then go=3'b010.
- Edge request:
  - Stimulus: assert b only on the CLEAR-exit cycle.
  - Required response: WALK entered; ped_pend never asserted.
- Request during WALK:
  - Stimulus: hold b high through all of WALK.
  - Required response: ped_pend stays 0; the next CLEAR goes directly to GO.
- Async reset mid-WARN:
  - Stimulus: pull reset_n low mid-WARN, with ped_pend=1.
  - Required response: outputs go to reset values without waiting for a clock edge; ped_pend=0; startup sequence repeats.
